// File: rtl/riscv_dec_pkg.sv
// Opcode constants and decoded-format encodings shared by the decode stage.
package riscv_dec_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

endpackage

// File: rtl/imm_format_gen.sv
// Combinational opcode classifier and immediate builder; zero latency, no handshake.
module imm_format_gen
  import riscv_dec_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output fmt_e            fmt,
  output logic            illegal,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic        s;

  assign s = instr[31];

  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b1;
    imm32   = '0;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: begin
        fmt     = FMT_I;
        illegal = 1'b0;
        imm32   = {{20{s}}, instr[31:20]};
      end
      OP_STORE: begin
        fmt     = FMT_S;
        illegal = 1'b0;
        imm32   = {{20{s}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt     = FMT_B;
        illegal = 1'b0;
        imm32   = {{19{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt     = FMT_U;
        illegal = 1'b0;
        imm32   = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt     = FMT_J;
        illegal = 1'b0;
        imm32   = {{11{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_OP, OP_OP32: begin
        fmt     = FMT_R;
        illegal = 1'b0;
      end
      default: ;
    endcase
  end

  // Every format's msb is instr[31], so one 32->XLEN extension covers all.
  assign imm = {{(XLEN-32){imm32[31]}}, imm32};

endmodule

// File: rtl/imm_decode_stage.sv
// Decode stage: classifies instr, builds immediate, buffers in a 2-entry skid queue.
// Accept at N -> dec_valid at N+1; instr_ready is registered from occupancy, so execute stalls never drop work.
module imm_decode_stage
  import riscv_dec_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc_in,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [XLEN-1:0]  dec_imm,
  output logic [2:0]       dec_fmt,
  output logic             dec_illegal,
  output logic [XLEN-1:0]  dec_pc,
  output logic [CNT_W-1:0] dec_count
);

  fmt_e            gen_fmt;
  logic            gen_illegal;
  logic [XLEN-1:0] gen_imm;

  imm_format_gen #(.XLEN(XLEN)) u_gen (
    .instr   (instr),
    .fmt     (gen_fmt),
    .illegal (gen_illegal),
    .imm     (gen_imm)
  );

  logic [XLEN-1:0] imm_q [2];
  logic [XLEN-1:0] pc_q  [2];
  fmt_e            fmt_q [2];
  logic            ill_q [2];

  logic       head, tail;
  logic [1:0] occ, occ_next;
  logic       ready_q;
  logic [CNT_W-1:0] count_q;
  logic       accept, pop;

  assign accept = instr_valid & ready_q;
  assign pop    = dec_valid & dec_ready;

  always_comb begin
    occ_next = occ;
    case ({accept, pop})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ     <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
      ready_q <= 1'b1;
      count_q <= '0;
      for (int i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
        fmt_q[i] <= FMT_R;
        ill_q[i] <= 1'b0;
      end
    end else begin
      if (pop) count_q <= count_q + 1'b1;
      // Flush wins over a same-cycle accept; storage is left stale on purpose.
      if (flush) begin
        occ     <= '0;
        head    <= 1'b0;
        tail    <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        if (accept) begin
          imm_q[tail] <= gen_imm;
          pc_q[tail]  <= pc_in;
          fmt_q[tail] <= gen_fmt;
          ill_q[tail] <= gen_illegal;
          tail        <= ~tail;
        end
        if (pop) head <= ~head;
        occ     <= occ_next;
        ready_q <= (occ_next < 2'd2);
      end
    end
  end

  assign instr_ready = ready_q;
  assign dec_valid   = (occ != 2'd0);
  assign dec_imm     = imm_q[head];
  assign dec_pc      = pc_q[head];
  assign dec_fmt     = fmt_q[head];
  assign dec_illegal = ill_q[head];
  assign dec_count   = count_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed plus randomized bench for imm_decode_stage with a queue-based reference model.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, instr_valid, dec_ready;
  logic [31:0] instr;
  logic [63:0] pc_in;
  logic        instr_ready, dec_valid, dec_illegal;
  logic [63:0] dec_imm, dec_pc;
  logic [2:0]  dec_fmt;
  logic [31:0] dec_count;

  imm_decode_stage #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc_in(pc_in),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_imm(dec_imm), .dec_fmt(dec_fmt), .dec_illegal(dec_illegal),
    .dec_pc(dec_pc), .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t        model_q[$];
  logic [31:0] model_count;
  logic        last_acc;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode from the format rules using arithmetic on a sign-extended word.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [63:0] pc);
    exp_t               e;
    logic signed [63:0] sx;
    logic [63:0]        t;
    sx    = {{32{ins[31]}}, ins};
    e.pc  = pc;
    e.ill = 1'b0;
    e.imm = 64'd0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: begin e.fmt = 3'd1; t = sx >>> 20; e.imm = t; end
      7'h23: begin
        e.fmt = 3'd2; t = sx >>> 25;
        e.imm = (t << 5) | 64'(ins[11:7]);
      end
      7'h63: begin
        e.fmt = 3'd3; t = sx >>> 31;
        e.imm = (t << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      end
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = sx & ~64'hFFF; end
      7'h6F: begin
        e.fmt = 3'd5; t = sx >>> 31;
        e.imm = (t << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
      end
      7'h33, 7'h3B: e.fmt = 3'd0;
      default: begin e.fmt = 3'd7; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  // One clock: check against model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic acc, pp;
    @(negedge clk);
    if (!reset) begin
      check("dec_valid", 64'(dec_valid), 64'(model_q.size() != 0));
      check("instr_ready", 64'(instr_ready), 64'(model_q.size() < 2));
      check("dec_count", 64'(dec_count), 64'(model_count));
      if (model_q.size() != 0) begin
        check("head_imm", dec_imm, model_q[0].imm);
        check("head_pc", dec_pc, model_q[0].pc);
        check("head_fmt", 64'(dec_fmt), 64'(model_q[0].fmt));
        check("head_illegal", 64'(dec_illegal), 64'(model_q[0].ill));
      end
    end
    @(posedge clk);
    acc = instr_valid && (model_q.size() < 2);
    pp  = (model_q.size() != 0) && dec_ready;
    last_acc = 1'b0;
    if (reset) begin
      model_q.delete();
      model_count = 32'd0;
    end else begin
      if (pp) model_count = model_count + 32'd1;
      if (flush) model_q.delete();
      else begin
        if (pp) void'(model_q.pop_front());
        if (acc) begin
          model_q.push_back(ref_dec(instr, pc_in));
          last_acc = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(dec_valid), 64'd0);
    check({tag, "_ready"}, 64'(instr_ready), 64'd1);
    check({tag, "_imm"}, dec_imm, 64'd0);
    check({tag, "_fmt"}, 64'(dec_fmt), 64'd0);
    check({tag, "_illegal"}, 64'(dec_illegal), 64'd0);
    check({tag, "_pc"}, dec_pc, 64'd0);
    check({tag, "_count"}, 64'(dec_count), 64'd0);
  endtask

  logic [31:0] vec_instr [5];
  logic [2:0]  vec_fmt   [5];
  logic [63:0] vec_imm   [5];
  logic [6:0]  opc_tab   [12];
  logic [31:0] c0;

  initial begin
    vec_instr = '{32'hFFF00093, 32'h01E080A3, 32'h02000063, 32'h0200006F, 32'h01F08038};
    vec_fmt   = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd7};
    vec_imm   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h20, 64'h20, 64'h0};
    opc_tab   = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                  7'h6F, 7'h33, 7'h3B, 7'h38};
    model_count = 32'd0;
    last_acc = 1'b0;
    reset = 1'b1; flush = 1'b0; instr_valid = 1'b0; dec_ready = 1'b0;
    instr = 32'd0; pc_in = 64'd0;
    cycle(); cycle();
    check_reset_outputs("reset");
    reset = 1'b0;

    // addi immediate 0x100
    instr = 32'h10010093; pc_in = 64'h1000; instr_valid = 1'b1; dec_ready = 1'b1;
    cycle();
    instr_valid = 1'b0;
    check("addi_valid", 64'(dec_valid), 64'd1);
    check("addi_fmt", 64'(dec_fmt), 64'd1);
    check("addi_imm", dec_imm, 64'h100);
    cycle();

    // one vector per format, streamed back-to-back
    for (int i = 0; i < 5; i++) begin
      instr = vec_instr[i]; pc_in = 64'h2000 + 64'(i * 4); instr_valid = 1'b1;
      cycle();
      check($sformatf("fmt_vec%0d", i), 64'(dec_fmt), 64'(vec_fmt[i]));
      check($sformatf("imm_vec%0d", i), dec_imm, vec_imm[i]);
      check($sformatf("ill_vec%0d", i), 64'(dec_illegal), 64'(vec_fmt[i] == 3'd7));
    end
    instr_valid = 1'b0;
    cycle();

    // back-pressure: third instruction held by fetch until space frees
    c0 = model_count;
    dec_ready = 1'b0; instr_valid = 1'b1;
    instr = 32'h00100093; pc_in = 64'h3000; cycle();
    instr = 32'h00200113; pc_in = 64'h3004; cycle();
    instr = 32'h00300193; pc_in = 64'h3008; cycle();
    check("full_ready", 64'(instr_ready), 64'd0);
    check("full_third_not_taken", 64'(last_acc), 64'd0);
    dec_ready = 1'b1;
    for (int i = 0; i < 8 && !last_acc; i++) cycle();
    check("third_taken", 64'(last_acc), 64'd1);
    instr_valid = 1'b0;
    cycle(); cycle();
    check("count_plus3", 64'(dec_count), 64'(c0 + 32'd3));

    // flush while full, with a same-cycle instruction that must vanish
    dec_ready = 1'b0; instr_valid = 1'b1;
    instr = 32'h00400213; pc_in = 64'h4000; cycle();
    instr = 32'h00500293; pc_in = 64'h4004; cycle();
    instr = 32'h00600313; pc_in = 64'h4008; flush = 1'b1; cycle();
    flush = 1'b0; instr_valid = 1'b0;
    check("flush_valid", 64'(dec_valid), 64'd0);
    check("flush_ready", 64'(instr_ready), 64'd1);
    dec_ready = 1'b1;
    cycle(); cycle();

    // continuous stream: occupancy stays at one, no bubbles
    instr_valid = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      instr = {$urandom_range(33554431, 0), opc_tab[$urandom_range(11, 0)]};
      pc_in = {$urandom(), $urandom()};
      cycle();
      check("stream_no_bubble", 64'(dec_valid && instr_ready), 64'd1);
    end

    // random traffic with occasional flush; fetch holds an un-taken instr
    instr_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!instr_valid || last_acc) begin
        instr = {$urandom_range(33554431, 0), opc_tab[$urandom_range(11, 0)]};
        if ($urandom_range(7, 0) == 0) instr = $urandom();
        pc_in = {$urandom(), $urandom()};
        instr_valid = ($urandom_range(3, 0) != 0);
      end
      dec_ready = ($urandom_range(2, 0) != 0);
      flush = ($urandom_range(29, 0) == 0);
      cycle();
    end
    flush = 1'b0;

    // reset with two entries queued
    instr_valid = 1'b1; dec_ready = 1'b0;
    instr = 32'hABCDE0B7; pc_in = 64'h5000; cycle();
    instr = 32'h8000006F; pc_in = 64'h5004; cycle();
    instr_valid = 1'b0;
    reset = 1'b1; cycle();
    check_reset_outputs("midreset");
    reset = 1'b0;
    cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
